// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the core (port 0)
// and the debug/loader port (port 1), sequencing each access as ISSUE then COMPLETE.
module dmem_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              wr0,
    input  logic              rd0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              wr1,
    input  logic              rd1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,
    output logic              core_stall,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              WR,
    output logic              RD,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WRData,
    output logic [DATA_W-1:0] RDData
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_COMPLETE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_owner, r_last, r_rd;
    logic              r_mem_wr, r_mem_rd;
    logic              r_gnt0, r_gnt1, r_done0, r_done1;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata0, r_rdata1, r_rddata;

    logic              w_win_valid, w_winner, w_sel_wr, w_sel_rd;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata, w_ret;

    // Winner: the sole requester, or on a tie whoever did not win last time.
    always_comb begin
        w_win_valid = req0 | req1;
        if (req0 && req1) begin
            w_winner = ~r_last;
        end else if (req1) begin
            w_winner = 1'b1;
        end else begin
            w_winner = 1'b0;
        end
    end

    // Mux the winning requester's access fields.
    always_comb begin
        if (w_winner) begin
            w_sel_wr    = wr1;
            w_sel_rd    = rd1;
            w_sel_addr  = addr1;
            w_sel_wdata = wdata1;
        end else begin
            w_sel_wr    = wr0;
            w_sel_rd    = rd0;
            w_sel_addr  = addr0;
            w_sel_wdata = wdata0;
        end
    end

    assign w_ret = r_rd ? mem_rdata : {DATA_W{1'b0}};

    // Access sequencer: arbitrate in IDLE/COMPLETE, one ISSUE cycle, one COMPLETE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_rd     <= 1'b0;
            r_mem_wr <= 1'b0;
            r_mem_rd <= 1'b0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_addr   <= {ADDR_W{1'b0}};
            r_wdata  <= {DATA_W{1'b0}};
            r_rdata0 <= {DATA_W{1'b0}};
            r_rdata1 <= {DATA_W{1'b0}};
            r_rddata <= {DATA_W{1'b0}};
        end else begin
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_mem_wr <= 1'b0;
            r_mem_rd <= 1'b0;
            case (r_state)
                S_IDLE, S_COMPLETE: begin
                    if (r_state == S_COMPLETE) begin
                        if (r_owner) begin
                            r_rdata1 <= w_ret;
                        end else begin
                            r_rdata0 <= w_ret;
                        end
                        if (r_rd) begin
                            r_rddata <= mem_rdata;
                        end
                    end
                    if (w_win_valid) begin
                        // A write with both strobes set suppresses the read.
                        r_rd     <= w_sel_rd & ~w_sel_wr;
                        r_mem_wr <= w_sel_wr;
                        r_mem_rd <= w_sel_rd & ~w_sel_wr;
                        r_addr   <= w_sel_addr;
                        r_wdata  <= w_sel_wdata;
                        r_owner  <= w_winner;
                        r_last   <= w_winner;
                        r_gnt0   <= ~w_winner;
                        r_gnt1   <= w_winner;
                        r_state  <= S_ISSUE;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    r_done0 <= ~r_owner;
                    r_done1 <= r_owner;
                    r_state <= S_COMPLETE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign done0     = r_done0;
    assign done1     = r_done1;
    assign rdata0    = r_done0 ? w_ret : r_rdata0;
    assign rdata1    = r_done1 ? w_ret : r_rdata1;
    assign mem_wr    = r_mem_wr;
    assign mem_rd    = r_mem_rd;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign WR        = r_mem_wr;
    assign RD        = r_mem_rd;
    assign Address   = r_addr;
    assign WRData    = r_wdata;
    assign RDData    = (r_state == S_COMPLETE && r_rd) ? mem_rdata : r_rddata;
    assign core_stall = ~rst & req0 & ~(r_state == S_COMPLETE && !r_owner);

endmodule
